// File: rtl/usb_cmd_engine.sv
// rtl/usb_cmd_engine.sv - USB byte-stream command parser driving a req/ack word memory port
// Pops READ/WRITE/PING commands from the RX FIFO and pushes response bytes into the TX FIFO.
module usb_cmd_engine #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_empty,
  output logic              rx_rd_en,
  input  logic [7:0]        rx_dout,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [7:0]        tx_din,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_OPCODE, S_ADDR, S_LEN, S_WDATA, S_MEM, S_SEND, S_RESP
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic              is_write;
  logic [31:0]       shift_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        words_left;
  logic [31:0]       rdata_q;
  logic [7:0]        resp_byte;
  logic [31:0]       idle_cnt;

  logic        parsing;
  logic        payload;
  logic        pop;
  logic        timeout_hit;
  logic [31:0] shift_next;

  assign parsing     = (state == S_OPCODE) || payload;
  assign payload     = (state == S_ADDR) || (state == S_LEN) || (state == S_WDATA);
  // Gated by rst_n so the FIFO is never popped while the engine is held in reset.
  assign rx_rd_en    = rst_n & ~rx_empty & parsing;
  assign pop         = rx_rd_en;
  assign shift_next  = {rx_dout, shift_q[31:8]};
  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt + 32'd1 == 32'(TIMEOUT));
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign busy        = (state != S_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OPCODE;
      byte_cnt   <= 2'd0;
      is_write   <= 1'b0;
      shift_q    <= 32'd0;
      addr_q     <= '0;
      words_left <= 9'd0;
      rdata_q    <= 32'd0;
      resp_byte  <= 8'd0;
      idle_cnt   <= 32'd0;
      tx_wr_en   <= 1'b0;
      tx_din     <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 32'd0;
    end else begin
      tx_wr_en <= 1'b0;
      if (payload && !pop) idle_cnt <= idle_cnt + 32'd1;
      else                 idle_cnt <= 32'd0;

      case (state)
        S_OPCODE: begin
          if (pop) begin
            byte_cnt <= 2'd0;
            case (rx_dout)
              8'h01: begin is_write <= 1'b0; state <= S_ADDR; end
              8'h02: begin is_write <= 1'b1; state <= S_ADDR; end
              8'h03: begin resp_byte <= 8'h5A; state <= S_RESP; end
              default: begin resp_byte <= 8'hEE; state <= S_RESP; end
            endcase
          end
        end
        S_ADDR: begin
          if (pop) begin
            shift_q  <= shift_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              addr_q <= ADDR_W'(shift_next);
              state  <= is_write ? S_WDATA : S_LEN;
            end
          end else if (timeout_hit) begin
            state <= S_OPCODE;
          end
        end
        S_LEN: begin
          if (pop) begin
            words_left <= (rx_dout == 8'd0) ? 9'd256 : {1'b0, rx_dout};
            mem_we     <= 1'b0;
            mem_req    <= 1'b1;
            state      <= S_MEM;
          end else if (timeout_hit) begin
            state <= S_OPCODE;
          end
        end
        S_WDATA: begin
          if (pop) begin
            shift_q  <= shift_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_wdata <= shift_next;
              mem_we    <= 1'b1;
              mem_req   <= 1'b1;
              state     <= S_MEM;
            end
          end else if (timeout_hit) begin
            state <= S_OPCODE;
          end
        end
        S_MEM: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              resp_byte <= 8'hA5;
              state     <= S_RESP;
            end else begin
              rdata_q  <= mem_rdata;
              byte_cnt <= 2'd0;
              state    <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (!tx_full) begin
            tx_wr_en <= 1'b1;
            tx_din   <= rdata_q[{byte_cnt, 3'b000} +: 8];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              words_left <= words_left - 9'd1;
              addr_q     <= addr_q + ADDR_W'(4);
              if (words_left == 9'd1) begin
                state <= S_OPCODE;
              end else begin
                mem_req <= 1'b1;
                state   <= S_MEM;
              end
            end
          end
        end
        S_RESP: begin
          if (!tx_full) begin
            tx_wr_en <= 1'b1;
            tx_din   <= resp_byte;
            state    <= S_OPCODE;
          end
        end
        default: state <= S_OPCODE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_cmd_engine.sv
// tb/tb_usb_cmd_engine.sv - scoreboard bench for usb_cmd_engine
// Commands are turned into expected TX bytes and memory ops; monitors pop and compare.
`timescale 1ns/1ps
module tb_usb_cmd_engine;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_empty, rx_rd_en;
  logic [7:0]  rx_dout;
  logic        tx_full, tx_wr_en;
  logic [7:0]  tx_din;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  usb_cmd_engine #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_empty(rx_empty), .rx_rd_en(rx_rd_en), .rx_dout(rx_dout),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_din(tx_din),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_op_t;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  mem_op_t     exp_mem[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_checks = 0, n_pass = 0;
  int pop_count = 0, tx_count = 0;
  bit rx_gaps = 0, rand_full = 0, force_full = 0, spur_en = 0;
  int fixed_lat = 3;
  logic full_seen = 1'b0;
  logic last_busy = 1'b1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Contents of never-written memory locations.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem_arr[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic send_read(input logic [31:0] addr, input logic [7:0] len);
    int n;
    logic [31:0] a, w;
    n = (len == 8'd0) ? 256 : int'(len);
    a = addr & ~32'h3;
    for (int i = 0; i < n; i++) begin
      w = ref_rd(a);
      exp_mem.push_back('{1'b0, a, 32'h0});
      for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
      a = a + 32'd4;
    end
    rx_q.push_back(8'h01);
    for (int i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
    rx_q.push_back(len);
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a;
    a = addr & ~32'h3;
    ref_mem[a] = data;
    exp_mem.push_back('{1'b1, a, data});
    exp_tx.push_back(8'hA5);
    rx_q.push_back(8'h02);
    for (int i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
    for (int i = 0; i < 4; i++) rx_q.push_back(data[8*i +: 8]);
  endtask

  task automatic send_ping();
    exp_tx.push_back(8'h5A);
    rx_q.push_back(8'h03);
  endtask

  task automatic send_bad(input logic [7:0] op);
    exp_tx.push_back(8'hEE);
    rx_q.push_back(op);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_mem.size() == 0 && !busy) done = 1;
    end
    check_bit("wait_done_bound", done, 1'b1);
  endtask

  task automatic check_reset_outs();
    check_bit("rst_rx_rd_en", rx_rd_en, 1'b0);
    check_bit("rst_tx_wr_en", tx_wr_en, 1'b0);
    check_eq("rst_tx_din", 32'(tx_din), 32'h0);
    check_bit("rst_mem_req", mem_req, 1'b0);
    check_bit("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_bit("rst_busy", busy, 1'b0);
  endtask

  // RX FIFO model (first-word-fall-through), optional random empty gaps.
  initial begin
    bit pop_pending, stall;
    int stall_run;
    rx_empty = 1'b1; rx_dout = 8'h00; pop_pending = 0; stall_run = 0;
    forever begin
      @(negedge clk);
      if (pop_pending && rx_q.size() != 0) begin
        void'(rx_q.pop_front());
        pop_count++;
      end
      stall = rx_gaps && (stall_run < 4) && ($urandom_range(0, 3) == 0);
      if (rx_q.size() == 0 || stall || !rst_n) begin
        rx_empty = 1'b1;
        rx_dout  = 8'($urandom);
        if (stall) stall_run++;
      end else begin
        rx_empty  = 1'b0;
        rx_dout   = rx_q[0];
        stall_run = 0;
      end
      #1;
      pop_pending = rx_rd_en && !rx_empty;
    end
  end

  // TX FIFO full driver.
  initial begin
    tx_full = 1'b0;
    forever begin
      @(negedge clk);
      tx_full = rand_full ? ($urandom_range(0, 3) == 0) : force_full;
    end
  end

  // TX monitor: every push must match the next expected byte and follow a not-full edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      full_seen = tx_full;
      @(negedge clk);
      if (rst_n && tx_wr_en) begin
        tx_count++;
        check_bit("tx_no_push_when_full", full_seen, 1'b0);
        check_bit("tx_push_expected", exp_tx.size() != 0, 1'b1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          check_eq("tx_byte", 32'(tx_din), 32'(e));
          if (exp_tx.size() == 0) last_busy = busy;
        end
      end
    end
  end

  // Memory responder and memory-op scoreboard.
  initial begin
    bit pend, spur, skip;
    int lat;
    logic [31:0] cur_addr;
    mem_op_t e;
    mem_ack = 1'b0; mem_rdata = 32'h0; pend = 0; spur = 0; lat = 0; cur_addr = 32'h0;
    forever begin
      @(negedge clk);
      skip = 0;
      if (!rst_n) begin
        mem_ack = 1'b0; pend = 0; spur = 0;
      end else begin
        if (mem_ack) begin
          mem_ack = 1'b0;
          if (!spur) begin
            check_bit("mem_req_drop", mem_req, 1'b0);
            pend = 0;
            skip = 1;
          end
          spur = 0;
        end
        if (!skip) begin
          if (mem_req) begin
            if (!pend) begin
              pend = 1;
              lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
              cur_addr = mem_addr;
              check_bit("mem_req_expected", exp_mem.size() != 0, 1'b1);
              if (exp_mem.size() != 0) begin
                e = exp_mem.pop_front();
                check_bit("mem_we", mem_we, e.we);
                check_eq("mem_addr", mem_addr, e.addr);
                if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
              end
            end else begin
              check_eq("mem_addr_stable", mem_addr, cur_addr);
            end
            if (lat == 0) begin
              mem_ack = 1'b1;
              if (mem_we) mem_arr[mem_addr] = mem_wdata;
              else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
            end else begin
              lat--;
            end
          end else if (spur_en && $urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1; spur = 1; mem_rdata = $urandom;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, r;
    bit ok;
    logic [31:0] a;
    repeat (2) @(negedge clk);
    check_reset_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("idle_busy", busy, 1'b0);

    // Two-word read with 3-cycle ack latency.
    preload(32'h1000, 32'h11223344);
    preload(32'h1004, 32'h55667788);
    last_busy = 1'b1;
    send_read(32'h1000, 8'd2);
    wait_done();
    check_bit("read_busy_after_last_push", last_busy, 1'b0);

    // Write then read back.
    send_write(32'h8, 32'hDEADBEEF);
    send_read(32'h8, 8'd1);
    wait_done();

    // PING and unknown opcode back to back.
    c = pop_count;
    send_ping();
    send_bad(8'hFF);
    wait_done();
    check_eq("ping_bad_pops", pop_count - c, 2);

    // TX backpressure mid-word.
    c = tx_count;
    send_read(32'h40, 8'd1);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx_count > c) ok = 1;
    end
    check_bit("bp_first_push_bound", ok, 1'b1);
    force_full = 1;
    repeat (2) @(negedge clk);
    c2 = tx_count;
    repeat (10) @(negedge clk);
    check_eq("bp_no_push_while_full", tx_count - c2, 0);
    force_full = 0;
    wait_done();
    check_eq("bp_all_bytes", tx_count - c, 4);

    // Idle timeout mid-command, then recovery.
    c = tx_count;
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h00);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rx_q.size() == 0) ok = 1;
    end
    check_bit("to_pops_bound", ok, 1'b1);
    repeat (10) @(negedge clk);
    check_bit("to_still_busy", busy, 1'b1);
    repeat (10) @(negedge clk);
    check_bit("to_dropped", busy, 1'b0);
    check_eq("to_no_tx", tx_count - c, 0);
    send_ping();
    wait_done();

    // Asynchronous reset while sending a read response.
    c = tx_count;
    send_read(32'h80, 8'd4);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (tx_count >= c + 2) ok = 1;
    end
    check_bit("rst_send_bound", ok, 1'b1);
    force_full = 1;
    repeat (2) @(negedge clk);
    check_bit("busy_in_send", busy, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs();
    rx_q.delete();
    exp_tx.delete();
    exp_mem.delete();
    force_full = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_ping();
    wait_done();

    // Randomized traffic with FIFO gaps, backpressure, variable latency, stray acks.
    rand_full = 1; rx_gaps = 1; spur_en = 1; fixed_lat = -1;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      a = 32'h2000 + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
      if (r <= 3)      send_write(a, $urandom);
      else if (r <= 6) send_read(a, 8'($urandom_range(1, 6)));
      else if (r == 7) send_ping();
      else if (r == 8) send_bad(8'($urandom_range(4, 255)));
      else             send_bad(8'h00);
      if (i % 5 == 4) wait_done();
    end
    wait_done();

    // Address wrap with len 0 (256 words).
    c = tx_count;
    send_read(32'hFFFF_FFFC, 8'd0);
    wait_done();
    check_eq("wrap_tx_bytes", tx_count - c, 1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/usb_cmd_engine.md
Name: usb_cmd_engine

Overview:
Command engine between the USB byte FIFOs and the on-chip memory bus. It pops host bytes from the RX FIFO, which the FT232H bridge fills, and parses READ/WRITE/PING commands. It issues word accesses on a simple req/ack memory port. It pushes response bytes into the TX FIFO, which the bridge drains to the host.

Parameters:
ADDR_W, 32, memory byte-address width (bits [1:0] ignored, word aligned)
TIMEOUT, 1000000, idle cycles allowed between bytes of one command before it is dropped; 0 disables the timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_empty  in  1  RX FIFO empty
rx_rd_en  out  1  RX FIFO pop (first-word-fall-through: rx_dout valid while ~rx_empty)
rx_dout  in  8  RX FIFO head byte
tx_full  in  1  TX FIFO full
tx_wr_en  out  1  TX FIFO push
tx_din  out  8  TX FIFO write byte
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  word-aligned byte address
mem_wdata  out  32  write data
mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
mem_rdata  in  32  read data
busy  out  1  high whenever state != S_OPCODE

Behaviour:
- Reset: all state to S_OPCODE. rx_rd_en=0, tx_wr_en=0, tx_din=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0. Counters cleared. Async assertion mid-command discards partial command and any in-flight memory access.
- Command format (multi-byte fields little-endian):
  - 0x01 READ: addr[4], len[1]. len = word count; 0 means 256.
  - 0x02 WRITE: addr[4], data[4].
  - 0x03 PING: no payload.
- Responses:
  - READ: 4*N bytes, each word LS byte first.
  - WRITE: single byte 0xA5 after mem_ack.
  - PING: single byte 0x5A.
  - Unknown opcode: single byte 0xEE; the opcode byte is consumed.
- rx_rd_en = ~rx_empty & state in {S_OPCODE, S_ADDR, S_LEN, S_WDATA}. One byte consumed per cycle max. No RX pops during memory or response phases.
- tx_wr_en is asserted only when ~tx_full. One byte per cycle max. tx_din and tx_wr_en are registered.
- States:
  - S_OPCODE: pop byte. 0x01/0x02 -> S_ADDR (byte cnt=0). 0x03 -> S_RESP(0x5A). Other -> S_RESP(0xEE).
  - S_ADDR: 4 pops into addr[7:0]..[31:24]. After the 4th: READ -> S_LEN, WRITE -> S_WDATA.
  - S_LEN: pop -> words_left = (byte==0)?256:byte -> S_MEM.
  - S_WDATA: 4 pops into wdata -> S_MEM.
  - S_MEM: mem_req=1 with stable we/addr/wdata until a cycle with mem_ack=1; mem_req drops the next cycle. Read captures mem_rdata -> S_SEND (byte idx 0). Write -> S_RESP(0xA5).
  - S_SEND: push the 4 bytes of the captured word, stalling on tx_full. After byte 3: words_left-1; addr+4 (wraps modulo 2^ADDR_W). If words remain -> S_MEM, else -> S_OPCODE.
  - S_RESP: push one byte when ~tx_full -> S_OPCODE.
- Memory latency is unbounded; there is no timeout in S_MEM.
- Timeout: in S_ADDR/S_LEN/S_WDATA, the idle counter increments each cycle with no pop and clears on pop. Reaching TIMEOUT -> S_OPCODE, with no response and the partial command discarded. The counter is inactive in other states.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- READ, stream 01 00 10 00 00 02; memory returns 0x11223344 then 0x55667788 with 3-cycle ack latency -> mem_addr 0x1000 then 0x1004; TX bytes 44 33 22 11 88 77 66 55; busy falls after the last push.
- WRITE, stream 02 08 00 00 00 EF BE AD DE -> one mem_req with mem_we=1, addr 0x8, wdata 0xDEADBEEF; then TX 0xA5. Follow with READ len 1 at 0x8 -> EF BE AD DE.
- PING 03 and unknown FF back to back -> TX 5A then EE; two pops total.
- Backpressure: READ len 1 with tx_full held high for 10 cycles mid-word -> no tx_wr_en while full; all 4 bytes later delivered in order, none duplicated or lost.
- Wrap/len 0: READ addr 0xFFFFFFFC len 0 -> 256 memory reads; second address 0x00000000; 1024 TX bytes.
- Timeout/reset: with TIMEOUT=16, send 01 00 then stall 16 cycles -> back to S_OPCODE with no TX; a following 03 yields 5A. Assert rst_n low during S_SEND -> all outputs return to reset values immediately.
